// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle MIPS main controller: ALU operation
// codes, opcode/funct constants, FSM state encodings, datapath select codes
// and a helper that sorts an instruction into its execution class.
package mc_ctrl_pkg;

  // ALU operation codes driven on alu_op
  localparam logic [4:0] ALUOP_ADD  = 5'd0;
  localparam logic [4:0] ALUOP_SUB  = 5'd1;
  localparam logic [4:0] ALUOP_AND  = 5'd2;
  localparam logic [4:0] ALUOP_OR   = 5'd3;
  localparam logic [4:0] ALUOP_XOR  = 5'd4;
  localparam logic [4:0] ALUOP_NOR  = 5'd5;
  localparam logic [4:0] ALUOP_SLT  = 5'd6;
  localparam logic [4:0] ALUOP_SLTU = 5'd7;
  localparam logic [4:0] ALUOP_SLL  = 5'd8;
  localparam logic [4:0] ALUOP_SRL  = 5'd9;
  localparam logic [4:0] ALUOP_SRA  = 5'd10;
  localparam logic [4:0] ALUOP_LUI  = 5'd11;
  localparam logic [4:0] ALUOP_BNE  = 5'd12;
  localparam logic [4:0] ALUOP_BLEZ = 5'd13;
  localparam logic [4:0] ALUOP_BGTZ = 5'd14;
  localparam logic [4:0] ALUOP_BLTZ = 5'd15;
  localparam logic [4:0] ALUOP_BGEZ = 5'd16;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // REGIMM branch selects (IR[20:16])
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  // pc_source selects
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  // alu_src_a selects
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REGA  = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  // alu_src_b selects
  localparam logic [2:0] SRCB_REGB     = 3'd0;
  localparam logic [2:0] SRCB_FOUR     = 3'd1;
  localparam logic [2:0] SRCB_SEXT     = 3'd2;
  localparam logic [2:0] SRCB_SEXT_SH2 = 3'd3;
  localparam logic [2:0] SRCB_ZEXT     = 3'd4;

  // reg_dst selects
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // mem_to_reg selects
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // FSM states; encodings 12..15 are unused and recover to S_FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_WB_R    = 4'd3,
    S_EXEC_I  = 4'd4,
    S_WB_I    = 4'd5,
    S_MEM_ADR = 4'd6,
    S_MEM_RD  = 4'd7,
    S_WB_M    = 4'd8,
    S_MEM_WR  = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  // Execution class chosen in DECODE
  typedef enum logic [2:0] {
    IC_ILLEGAL = 3'd0,
    IC_RTYPE   = 3'd1,
    IC_IALU    = 3'd2,
    IC_MEM     = 3'd3,
    IC_BRANCH  = 3'd4,
    IC_JUMP    = 3'd5
  } iclass_e;

  // Classify the instruction held in IR; anything unsupported is IC_ILLEGAL
  function automatic iclass_e decode_class(input logic [5:0] op,
                                           input logic [5:0] fn,
                                           input logic [4:0] rt);
    iclass_e c;
    c = IC_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: c = IC_RTYPE;
          FN_JR:                           c = IC_JUMP;
          default:                         c = IC_ILLEGAL;
        endcase
      end
      OP_REGIMM: c = (rt == RT_BLTZ || rt == RT_BGEZ) ? IC_BRANCH : IC_ILLEGAL;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: c = IC_BRANCH;
      OP_J, OP_JAL:                     c = IC_JUMP;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: c = IC_IALU;
      OP_LW, OP_SW:                     c = IC_MEM;
      default:                          c = IC_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decoder: picks the alu_op code from the current FSM state
// and the IR fields. Purely combinational.
import mc_ctrl_pkg::*;

module mc_alu_dec (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] rt_i,
  input  state_e     state_i,
  output logic [4:0] alu_op_o
);

  // ADD by default (PC+4, branch target, effective address); per-op codes in execute/branch states
  always_comb begin
    alu_op_o = ALUOP_ADD;
    case (state_i)
      S_EXEC_R: begin
        case (funct_i)
          FN_SUB, FN_SUBU:  alu_op_o = ALUOP_SUB;
          FN_AND:           alu_op_o = ALUOP_AND;
          FN_OR:            alu_op_o = ALUOP_OR;
          FN_XOR:           alu_op_o = ALUOP_XOR;
          FN_NOR:           alu_op_o = ALUOP_NOR;
          FN_SLT:           alu_op_o = ALUOP_SLT;
          FN_SLTU:          alu_op_o = ALUOP_SLTU;
          FN_SLL, FN_SLLV:  alu_op_o = ALUOP_SLL;
          FN_SRL, FN_SRLV:  alu_op_o = ALUOP_SRL;
          FN_SRA, FN_SRAV:  alu_op_o = ALUOP_SRA;
          default:          alu_op_o = ALUOP_ADD;
        endcase
      end
      S_EXEC_I: begin
        case (opcode_i)
          OP_SLTI:  alu_op_o = ALUOP_SLT;
          OP_SLTIU: alu_op_o = ALUOP_SLTU;
          OP_ANDI:  alu_op_o = ALUOP_AND;
          OP_ORI:   alu_op_o = ALUOP_OR;
          OP_XORI:  alu_op_o = ALUOP_XOR;
          OP_LUI:   alu_op_o = ALUOP_LUI;
          default:  alu_op_o = ALUOP_ADD;
        endcase
      end
      S_BRANCH: begin
        case (opcode_i)
          OP_BEQ:    alu_op_o = ALUOP_SUB;
          OP_BNE:    alu_op_o = ALUOP_BNE;
          OP_BLEZ:   alu_op_o = ALUOP_BLEZ;
          OP_BGTZ:   alu_op_o = ALUOP_BGTZ;
          OP_REGIMM: alu_op_o = (rt_i == RT_BGEZ) ? ALUOP_BGEZ : ALUOP_BLTZ;
          default:   alu_op_o = ALUOP_SUB;
        endcase
      end
      default: alu_op_o = ALUOP_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle main-control FSM for the MIPS subset. Sequences PC, IR, ALU,
// register file and memory port; stalls in FETCH/MEM_RD/MEM_WR until
// mem_ready. Optional performance counters: define MC_PERF_CNT_EN.
import mc_ctrl_pkg::*;

module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       rt,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic [1:0]       alu_src_a,
  output logic [2:0]       alu_src_b,
  output logic [4:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             illegal_instr,
`ifdef MC_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
`endif
  output logic [3:0]       state_o
);

  state_e     state_q, state_d;
  iclass_e    iclass;
  logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c, pc_write_cond_c;
  logic       reg_write_c, illegal_c;
  logic [1:0] pc_source_c, alu_src_a_c, reg_dst_c, mem_to_reg_c;
  logic [2:0] alu_src_b_c;
  logic [4:0] alu_op_c;

  // The zero flag gates pc_write_cond inside the datapath, not here
  logic unused_zero;
  assign unused_zero = zero;

  assign iclass = decode_class(opcode, funct, rt);

  mc_alu_dec u_alu_dec (
    .opcode_i (opcode),
    .funct_i  (funct),
    .rt_i     (rt),
    .state_i  (state_q),
    .alu_op_o (alu_op_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and Moore output decode (FETCH enables are mem_ready-gated)
  always_comb begin
    state_d         = state_q;
    mem_req_c       = 1'b0;
    mem_we_c        = 1'b0;
    iord_c          = 1'b0;
    ir_write_c      = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_source_c     = PCSRC_ALU;
    alu_src_a_c     = SRCA_PC;
    alu_src_b_c     = SRCB_REGB;
    reg_write_c     = 1'b0;
    reg_dst_c       = REGDST_RT;
    mem_to_reg_c    = M2R_ALUOUT;
    illegal_c       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        ir_write_c  = mem_ready;
        pc_write_c  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = SRCB_SEXT_SH2;
        case (iclass)
          IC_RTYPE:  state_d = S_EXEC_R;
          IC_IALU:   state_d = S_EXEC_I;
          IC_MEM:    state_d = S_MEM_ADR;
          IC_BRANCH: state_d = S_BRANCH;
          IC_JUMP:   state_d = S_JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        // Immediate shifts take the shift amount from IR[10:6] on port A
        if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)
          alu_src_a_c = SRCA_SHAMT;
        else
          alu_src_a_c = SRCA_REGA;
        alu_src_b_c = SRCB_REGB;
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        reg_write_c = 1'b1;
        reg_dst_c   = REGDST_RD;
        state_d     = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a_c = SRCA_REGA;
        // Logical immediates are zero-extended, the rest sign-extended
        if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
          alu_src_b_c = SRCB_ZEXT;
        else
          alu_src_b_c = SRCB_SEXT;
        state_d = S_WB_I;
      end
      S_WB_I: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_ADR: begin
        alu_src_a_c = SRCA_REGA;
        alu_src_b_c = SRCB_SEXT;
        state_d     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) state_d = S_WB_M;
      end
      S_WB_M: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = M2R_MDR;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c     = SRCA_REGA;
        alu_src_b_c     = SRCB_REGB;
        pc_write_cond_c = 1'b1;
        pc_source_c     = PCSRC_ALUOUT;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        if (opcode == OP_RTYPE) begin
          pc_source_c = PCSRC_REGA;
        end else begin
          pc_source_c = PCSRC_JUMP;
          if (opcode == OP_JAL) begin
            reg_write_c  = 1'b1;
            reg_dst_c    = REGDST_RA;
            mem_to_reg_c = M2R_PC;
          end
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every enable and select low, abandoning any access in flight
  assign mem_req       = mem_req_c & ~rst;
  assign mem_we        = mem_we_c & ~rst;
  assign iord          = iord_c & ~rst;
  assign ir_write      = ir_write_c & ~rst;
  assign pc_write      = pc_write_c & ~rst;
  assign pc_write_cond = pc_write_cond_c & ~rst;
  assign reg_write     = reg_write_c & ~rst;
  assign illegal_instr = illegal_c & ~rst;
  assign pc_source     = rst ? 2'd0 : pc_source_c;
  assign alu_src_a     = rst ? 2'd0 : alu_src_a_c;
  assign alu_src_b     = rst ? 3'd0 : alu_src_b_c;
  assign alu_op        = rst ? 5'd0 : alu_op_c;
  assign reg_dst       = rst ? 2'd0 : reg_dst_c;
  assign mem_to_reg    = rst ? 2'd0 : mem_to_reg_c;
  assign state_o       = state_q;

`ifdef MC_PERF_CNT_EN
  logic             retire_c;
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

  // An instruction retires when its last state hands back to FETCH
  always_comb begin
    retire_c = 1'b0;
    case (state_q)
      S_WB_R, S_WB_I, S_WB_M, S_BRANCH, S_JUMP: retire_c = 1'b1;
      S_MEM_WR:                                 retire_c = mem_ready;
      default:                                  retire_c = 1'b0;
    endcase
  end

  // Free-running cycle and retired-instruction counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (retire_c) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle main-control FSM that sequences the shared datapath ALU, PC, IR, register file and memory port for the MIPS subset.
- Decodes the opcode/funct held in IR. Drives per-state mux selects, write enables and the 5-bit ALU opcode, using the existing ALUOP_* encodings.
- Stalls on a memory ready handshake.
- Sits between the IR/ALU-zero feedback and every datapath control input.

Parameters:
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
rt  in  5  IR[20:16], REGIMM branch select
zero  in  1  ALU zero flag; 1 means branch taken for every branch ALUOp
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access active
mem_we  out  1  write access (sw)
iord  out  1  0 = address from PC, 1 = address from ALUOut
ir_write  out  1  latch IR
pc_write  out  1  unconditional PC write
pc_write_cond  out  1  PC write gated by zero
pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = regA
alu_src_a  out  2  0 = PC, 1 = regA, 2 = shamt zero-extended
alu_src_b  out  3  0 = regB, 1 = const 4, 2 = sext imm, 3 = sext imm<<2, 4 = zext imm
alu_op  out  5  ALUOP_* code
reg_write  out  1  register file write
reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC
illegal_instr  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct
state_o  out  4  current state, for debug

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset: state <= FETCH. While rst=1, every enable (mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write, illegal_instr) is 0 and every select is 0. rst mid-access abandons the access with no writes.
- Outputs are Moore decodes of state, except ir_write and pc_write in FETCH, which are mem_ready-gated.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - ir_write=pc_write=mem_ready.
  - Stay while mem_ready=0; on mem_ready go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut).
  - Next state: R-type to EXEC_R; I-ALU to EXEC_I; lw/sw to MEM_ADR; beq/bne/blez/bgtz/REGIMM to BRANCH; j/jal/jr to JUMP.
  - Illegal: pulse illegal_instr, go to FETCH.
- EXEC_R:
  - Shifts sll/srl/sra: alu_src_a=2. Variable shifts and other R-type: alu_src_a=1. alu_src_b=0 in both cases.
  - funct map: add/addu ADD, sub/subu SUB, and/or/xor/nor, slt, sltu, sll(v)/srl(v)/sra(v).
  - Next state: WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; go to FETCH.
- EXEC_I:
  - alu_src_a=1. alu_src_b=4 for andi/ori/xori, else 2.
  - ops: addi/addiu ADD, slti SLT, sltiu SLTU, lui LUI.
  - Next state: WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0; go to FETCH.
- MEM_ADR: alu_src_a=1, alu_src_b=2, ADD; lw goes to MEM_RD, sw to MEM_WR.
- MEM_RD: mem_req=1, iord=1; hold until mem_ready, then go to WB_M.
- WB_M: reg_write=1, reg_dst=0, mem_to_reg=1; go to FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; hold until mem_ready, then go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, pc_write_cond=1, pc_source=1.
  - ops: beq SUB, bne BNE, blez BLEZ, bgtz BGTZ; REGIMM rt=0 BLTZ, rt=1 BGEZ (other rt illegal in DECODE).
  - Next state: FETCH.
- JUMP:
  - pc_write=1. j: pc_source=2. jal: pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2. jr: pc_source=3.
  - Next state: FETCH.
- Latency with mem_ready tied to 1: R-type/I-ALU 4 cycles, lw 5, sw 4, branch/jump 3. Each wait cycle adds 1 in FETCH/MEM_RD/MEM_WR.
- Unused state encodings recover to FETCH on the next cycle.

Optional Feature:
- MC_PERF_CNT_EN defined:
  - Adds outputs cycle_cnt[CNT_W] and instr_cnt[CNT_W], both cleared by rst.
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on each transition into FETCH from a retiring state. Illegal instructions are not counted.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: no counters, no ports.

Decomposition:
- Shared include: existing ALUOP_* codes, plus OP_*/FUNCT_* opcode constants, state encodings, and pc_source/alu_src/reg_dst/mem_to_reg select constants.
- One combinational sub-module mc_alu_dec (opcode, funct, rt, state -> alu_op). The FSM lives in mc_ctrl.

Test Plan:
- rst held 3 cycles then released, mem_ready=1 -> all enables 0 during reset; state_o=FETCH; ir_write=pc_write=1 in the first post-reset cycle.
- add (op 000000, funct 100000), mem_ready=1 -> FETCH, DECODE, EXEC_R (alu_op=ADD, src_a=1, src_b=0), WB_R (reg_write=1, reg_dst=1); 4 cycles.
- lw (100011) with mem_ready low 2 cycles in MEM_RD -> 7 cycles total; WB_M has mem_to_reg=1; no reg_write before mem_ready.
- bne (000101) with zero=1, then zero=0 -> BRANCH in 3rd cycle, alu_op=BNE, pc_write_cond=1, pc_source=1.
- jal (000011) -> JUMP: pc_write=1, reg_dst=2, mem_to_reg=2, reg_write=1.
- opcode 111111 -> illegal_instr=1 for one cycle in DECODE, next state FETCH, no reg/mem write; with MC_PERF_CNT_EN, instr_cnt unchanged.
